// File: rtl/shape_cmd_sequencer_pkg.sv
// Shared types and helpers for the shape_processor command sequencer:
// SFR field encodings, the packed ctrl word, and legality checks.
package shape_cmd_sequencer_pkg;

  typedef enum logic [1:0] {
    SHAPE_RECTANGLE = 2'b01,
    SHAPE_TRIANGLE  = 2'b10
  } shape_e;

  typedef enum logic [4:0] {
    OP_CODE_00 = 5'b00000,
    OP_CODE_01 = 5'b00001,
    OP_CODE_08 = 5'b01000,
    OP_CODE_10 = 5'b10000,
    OP_CODE_11 = 5'b10001
  } operation_e;

  typedef struct packed {
    logic [13:0] rsvd_hi;
    logic [1:0]  shape;
    logic [10:0] rsvd_lo;
    logic [4:0]  operation;
  } ctrl_sfr_reg;

  typedef struct packed {
    logic [1:0] shape;
    logic [4:0] operation;
  } cmd_t;

  localparam int unsigned CMD_W = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WAIT  = 3'd2,
    S_READ  = 3'd3,
    S_RESP  = 3'd4
  } seq_state_e;

  function automatic logic is_legal_shape(input logic [1:0] shape);
    logic legal;
    case (shape)
      SHAPE_RECTANGLE, SHAPE_TRIANGLE: legal = 1'b1;
      default:                         legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic is_legal_operation(input logic [4:0] operation);
    logic legal;
    case (operation)
      OP_CODE_00, OP_CODE_01, OP_CODE_08, OP_CODE_10, OP_CODE_11: legal = 1'b1;
      default:                                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic ctrl_sfr_reg pack_ctrl(input logic [1:0] shape, input logic [4:0] operation);
    ctrl_sfr_reg ctrl;
    ctrl           = '0;
    ctrl.shape     = shape;
    ctrl.operation = operation;
    return ctrl;
  endfunction

endpackage

// File: rtl/shape_cmd_fifo.sv
// Synchronous show-ahead FIFO for queued commands; wrap-bit pointers give
// full/empty without a separate occupancy counter.
module shape_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on accepted push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer and storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_ok) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata;
      end
    end
  end

endmodule

// File: rtl/shape_cmd_sequencer_props.sv
// Interface properties for shape_cmd_sequencer: strobe exclusivity, single-cycle
// strobes and response stability under back-pressure.
module shape_cmd_sequencer_props (
  input logic        clk,
  input logic        rst_n,
  input logic        write,
  input logic        read,
  input logic        rsp_valid,
  input logic        rsp_ready,
  input logic [31:0] rsp_data,
  input logic        rsp_error,
  input logic        rsp_illegal
);

  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(write && read));

  a_write_width: assert property (@(posedge clk) disable iff (!rst_n) write |=> !write);

  a_read_width: assert property (@(posedge clk) disable iff (!rst_n) read |=> !read);

  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=>
      (rsp_valid && $stable(rsp_data) && $stable(rsp_error) && $stable(rsp_illegal)));

endmodule

// File: rtl/shape_cmd_sequencer.sv
// Command front end for shape_processor: queues (shape, operation) commands and
// replays each as one SFR write then one SFR read, returning data and status.
module shape_cmd_sequencer
  import shape_cmd_sequencer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_shape,
  input  logic [4:0]  cmd_operation,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic        rsp_illegal,
  output logic        write,
  output logic [31:0] write_data,
  output logic        read,
  input  logic [31:0] read_data,
  input  logic        error,
  output logic        busy
);

  seq_state_e       state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [CMD_W-1:0] fifo_wdata;
  logic [CMD_W-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  logic             write_q;
  logic [31:0]      write_data_q;
  logic             read_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_data_q;
  logic             rsp_error_q;
  logic             rsp_illegal_q;

  assign fifo_wdata = {cmd_shape, cmd_operation};

  shape_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sequencing FSM: one command in flight, popped only from IDLE
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = cmd_t'(fifo_rdata);
          state_d  = S_WRITE;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_WRITE: state_d = S_WAIT;
      S_WAIT:  state_d = S_READ;
      S_READ:  state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and in-flight command registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  // Strobes are registered from the next state so they align with WRITE/READ/RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q       <= 1'b0;
      write_data_q  <= 32'd0;
      read_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 32'd0;
      rsp_error_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      write_q      <= (state_d == S_WRITE);
      write_data_q <= (state_d == S_WRITE) ? pack_ctrl(cmd_d.shape, cmd_d.operation) : 32'd0;
      read_q       <= (state_d == S_READ);
      rsp_valid_q  <= (state_d == S_RESP);
      if (state_q == S_WAIT) begin
        rsp_error_q <= error;
      end
      if (state_q == S_READ) begin
        rsp_data_q <= read_data;
      end
      if (fifo_pop) begin
        rsp_illegal_q <= !(is_legal_shape(cmd_d.shape) && is_legal_operation(cmd_d.operation));
      end
    end
  end

  assign cmd_ready   = !fifo_full;
  assign busy        = (state_q != S_IDLE) || !fifo_empty;
  assign write       = write_q;
  assign write_data  = write_data_q;
  assign read        = read_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_shape_cmd_sequencer.sv
// Directed bench for shape_cmd_sequencer: table of single commands plus
// back-pressure, reset and pointer-wrap sequences.
module tb_shape_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_shape;
  logic [4:0]  cmd_operation;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        rsp_illegal;
  logic        write;
  logic [31:0] write_data;
  logic        read;
  logic [31:0] read_data;
  logic        error;
  logic        busy;

  int total;
  int bad;

  typedef struct {
    logic [1:0]  shape;
    logic [4:0]  op;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        ill;
  } vec_t;

  vec_t vt [8];
  int   exp_q [$];

  shape_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_shape(cmd_shape), .cmd_operation(cmd_operation), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .rsp_illegal(rsp_illegal), .write(write), .write_data(write_data), .read(read),
    .read_data(read_data), .error(error), .busy(busy)
  );

  shape_cmd_sequencer_props u_props (
    .clk(clk), .rst_n(rst_n), .write(write), .read(read), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .rsp_illegal(rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Processor stand-in: error valid only in the cycle after write, read_data only while read;
  // the inverted values elsewhere catch sampling in the wrong cycle.
  initial begin : proc_model
    logic [31:0] mdl_w;
    logic        mdl_wr_prev;
    mdl_w       = 32'd0;
    mdl_wr_prev = 1'b0;
    error       = 1'b1;
    read_data   = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (write) mdl_w = write_data;
      error       = mdl_wr_prev ? mdl_w[3] : ~mdl_w[3];
      read_data   = read ? (mdl_w ^ 32'hA5A5_0000) : ~(mdl_w ^ 32'hA5A5_0000);
      mdl_wr_prev = write;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers command k until accepted; called and returns at posedge+1
  task automatic push_cmd(input int k, output int waited);
    waited        = 0;
    cmd_valid     = 1'b1;
    cmd_shape     = vt[k].shape;
    cmd_operation = vt[k].op;
    @(negedge clk);
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      chk("push_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
    end else begin
      tick();
      cmd_valid = 1'b0;
      exp_q.push_back(k);
    end
  endtask

  task automatic collect(input int n, input bit rnd, input int budget);
    int got = 0;
    int cyc = 0;
    int k;
    while (got < n && cyc < budget) begin
      rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          k = exp_q.pop_front();
          chk("seq_rsp_data", rsp_data, vt[k].rdata);
          chk("seq_rsp_error", 32'(rsp_error), 32'(vt[k].err));
          chk("seq_rsp_illegal", 32'(rsp_illegal), 32'(vt[k].ill));
        end
        got++;
      end
      tick();
      cyc++;
    end
    chk("rsp_count", 32'(got), 32'(n));
  endtask

  // Single command with cycle-exact checks relative to the acceptance cycle N
  task automatic run_one(input int k);
    int waited;
    rsp_ready = 1'b1;
    push_cmd(k, waited);
    chk("single_accept_wait", 32'(waited), 32'd0);
    void'(exp_q.pop_back());
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("v%0d_write_c%0d", k, c), 32'(write), 32'(c == 2));
      chk($sformatf("v%0d_read_c%0d", k, c), 32'(read), 32'(c == 4));
      chk($sformatf("v%0d_rsp_valid_c%0d", k, c), 32'(rsp_valid), 32'(c == 5));
      if (c == 2 || c == 3) chk($sformatf("v%0d_wdata_c%0d", k, c), write_data, (c == 2) ? vt[k].wdata : 32'd0);
      if (c == 5) begin
        chk($sformatf("v%0d_rsp_data", k), rsp_data, vt[k].rdata);
        chk($sformatf("v%0d_rsp_error", k), 32'(rsp_error), 32'(vt[k].err));
        chk($sformatf("v%0d_rsp_illegal", k), 32'(rsp_illegal), 32'(vt[k].ill));
      end
      tick();
    end
  endtask

  initial begin : main
    int waited;
    int guard;
    logic seen;
    total = 0;
    bad   = 0;
    //            shape   op        write_data    read_data     err   ill
    vt[0] = '{2'b01, 5'b00001, 32'h0001_0001, 32'hA5A4_0001, 1'b0, 1'b0};
    vt[1] = '{2'b11, 5'b00001, 32'h0003_0001, 32'hA5A6_0001, 1'b0, 1'b1};
    vt[2] = '{2'b10, 5'b10001, 32'h0002_0011, 32'hA5A7_0011, 1'b0, 1'b0};
    vt[3] = '{2'b01, 5'b01000, 32'h0001_0008, 32'hA5A4_0008, 1'b1, 1'b0};
    vt[4] = '{2'b10, 5'b00011, 32'h0002_0003, 32'hA5A7_0003, 1'b0, 1'b1};
    vt[5] = '{2'b00, 5'b11000, 32'h0000_0018, 32'hA5A5_0018, 1'b1, 1'b1};
    vt[6] = '{2'b10, 5'b00000, 32'h0002_0000, 32'hA5A7_0000, 1'b0, 1'b0};
    vt[7] = '{2'b01, 5'b10000, 32'h0001_0010, 32'hA5A4_0010, 1'b0, 1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_shape = 2'b00; cmd_operation = 5'b00000; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err_ill", {30'd0, rsp_error, rsp_illegal}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 8; k++) begin
      run_one(k);
      tick();
    end

    // Fill FIFO under back-pressure, then hold RESP
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(i, waited);
      chk($sformatf("fill_no_stall_%0d", i), 32'(waited), 32'd0);
    end
    cmd_valid = 1'b1; cmd_shape = vt[5].shape; cmd_operation = vt[5].op;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("full_cmd_ready_%0d", i), 32'(cmd_ready), 32'd0);
      chk($sformatf("full_busy_%0d", i), 32'(busy), 32'd1);
      tick();
    end
    cmd_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!rsp_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("hold_rsp_arrives", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      chk($sformatf("hold_valid_%0d", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("hold_data_%0d", i), rsp_data, vt[0].rdata);
      chk($sformatf("hold_error_%0d", i), 32'(rsp_error), 32'(vt[0].err));
      chk($sformatf("hold_no_strobe_%0d", i), {30'd0, write, read}, 32'd0);
    end
    tick();
    collect(5, 1'b0, 300);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen = seen | rsp_valid | write;
      tick();
    end
    chk("fill_no_extra_rsp", 32'(seen), 32'd0);
    chk("fill_drained_busy", 32'(busy), 32'd0);
    chk("fill_drained_ready", 32'(cmd_ready), 32'd1);

    // Reset while the first command sits in WAIT with two more queued
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_cmd(i, waited);
    exp_q.delete();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {29'd0, write, read, rsp_valid}, 32'd0);
    chk("mid_rst_write_data", write_data, 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      seen = seen | rsp_valid | write | read;
      tick();
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Pointer wrap with random back-pressure
    fork
      begin
        for (int i = 0; i < 9; i++) push_cmd(i % 8, waited);
      end
      collect(9, 1'b1, 800);
    join
    rsp_ready = 1'b1;
    repeat (3) tick();
    chk("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("wrap_idle_busy", 32'(busy), 32'd0);
    chk("wrap_idle_ready", 32'(cmd_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
